sap_ram_loader: RTL

//  Boot-time program loader and RAM-bus owner for the SAP-1 core.

---
 rtl/sap_ram_loader_pkg.sv | 19 +
 rtl/sap_ram_loader_if.sv | 27 ++
 rtl/sap_csum_acc.sv | 23 ++
 rtl/sap_ram_loader.sv | 131 +++++++++++++
 4 files changed

// File: rtl/sap_ram_loader_pkg.sv
// Shared definitions for the SAP-1 program loader: default geometry and FSM states.
package sap_loader_pkg;

  localparam int ADDR_W_DEF     = 4;
  localparam int DATA_W_DEF     = 8;
  localparam int LOAD_WORDS_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CSUM   = 3'd2,
    VERIFY = 3'd3,
    CHECK  = 3'd4,
    RUN    = 3'd5,
    HALTED = 3'd6,
    ERR    = 3'd7
  } state_e;

endpackage

// File: rtl/sap_ram_loader_if.sv
// Byte stream (valid/ready) plus program-RAM bus seen by the loader.
// master = loader side, slave = stream source / RAM side.
interface sap_ram_loader_if #(
  parameter int ADDR_W = sap_loader_pkg::ADDR_W_DEF,
  parameter int DATA_W = sap_loader_pkg::DATA_W_DEF
) ();

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic              own_ram;

  modport master (
    input  in_data, in_valid, ram_rdata,
    output in_ready, ram_addr, ram_wdata, ram_we, own_ram
  );

  modport slave (
    output in_data, in_valid, ram_rdata,
    input  in_ready, ram_addr, ram_wdata, ram_we, own_ram
  );

endinterface

// File: rtl/sap_csum_acc.sv
// Wrapping DATA_W-bit accumulator used for both the stream sum and the read-back sum.
module sap_csum_acc
  import sap_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sum
);

  // Running sum; the synchronous clear wins over an add in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    if (!rst_n)    sum <= '0;
    else if (sclr) sum <= '0;
    else if (en)   sum <= sum + din;
  end

endmodule

// File: rtl/sap_ram_loader.sv
// sap_ram_loader: loads a checksummed byte image into the SAP-1 program RAM,
// reads it back to confirm it, then hands the RAM bus to the MAR and releases the CPU.
module sap_ram_loader
  import sap_loader_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LOAD_WORDS = LOAD_WORDS_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  sap_ram_loader_if.master bus,
  output logic             cpu_clr,
  input  logic             cpu_hlt,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LOAD_WORDS - 1);

  state_e            state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_we;
  logic [DATA_W-1:0] rd_din;
  logic [DATA_W-1:0] sum_in;
  logic [DATA_W-1:0] sum_rd;
  logic              hs;
  logic              last_cnt;
  logic              restart;
  logic              in_add;
  logic              rd_add;

  assign hs       = bus.in_valid && bus.in_ready;
  assign last_cnt = (cnt == LAST_IDX);
  // start only counts when no image is in flight.
  assign restart  = start && (state inside {IDLE, RUN, HALTED, ERR});

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state and accumulator controls.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx = state;
    in_add   = 1'b0;
    rd_add   = 1'b0;
    rd_din   = bus.in_data;
    case (state)
      LOAD: if (hs) begin
        in_add = 1'b1;
        if (last_cnt) state_nx = CSUM;
      end
      // The checksum byte seeds the read-back sum too; it is never written to RAM.
      CSUM: if (hs) begin
        in_add   = 1'b1;
        rd_add   = 1'b1;
        state_nx = VERIFY;
      end
      VERIFY: begin
        rd_add = 1'b1;
        rd_din = bus.ram_rdata;
        if (last_cnt) state_nx = CHECK;
      end
      CHECK:   state_nx = (sum_in == '0 && sum_rd == '0) ? RUN : ERR;
      RUN:     if (cpu_hlt) state_nx = HALTED;
      default: ;
    endcase
    if (restart) state_nx = LOAD;
  end

  // Word counter and the registered RAM write port.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt     <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_we   <= 1'b0;
    end else begin
      wr_we <= 1'b0;
      if (restart) begin
        cnt     <= '0;
        wr_addr <= '0;
        wr_data <= '0;
      end else if ((state == LOAD && hs) || state == VERIFY) begin
        cnt <= last_cnt ? '0 : cnt + ADDR_W'(1);
      end
      if (state == LOAD && hs) begin
        wr_we   <= 1'b1;
        wr_addr <= cnt;
        wr_data <= bus.in_data;
      end
    end
  end

  sap_csum_acc #(.DATA_W(DATA_W)) u_sum_in (
    .clk   (clk),
    .rst_n (clr),
    .sclr  (restart),
    .en    (in_add),
    .din   (bus.in_data),
    .sum   (sum_in)
  );

  sap_csum_acc #(.DATA_W(DATA_W)) u_sum_rd (
    .clk   (clk),
    .rst_n (clr),
    .sclr  (restart),
    .en    (rd_add),
    .din   (rd_din),
    .sum   (sum_rd)
  );

  // Output decode; the CPU only owns the bus and runs in RUN/HALTED.
  assign bus.in_ready  = (state == LOAD) || (state == CSUM);
  assign bus.ram_we    = wr_we;
  assign bus.ram_addr  = (state == VERIFY) ? cnt : wr_addr;
  assign bus.ram_wdata = wr_data;
  assign bus.own_ram   = !(state inside {RUN, HALTED});
  assign cpu_clr       = !(state inside {RUN, HALTED});
  assign busy          = state inside {LOAD, CSUM, VERIFY};
  assign done          = (state == HALTED);
  assign err           = (state == ERR);

endmodule
